// File: rtl/spikes_pack_reshaper_if.sv
// Stream bundle for the spike-slice packer: narrow slice beats in, wide packed words out.
// The slave modport is the packer itself; the master modport is whoever feeds and drains it.
interface spikes_pack_reshaper_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 64,
  parameter int CNT_W = 4
);
  logic [IN_W-1:0]  i_spikes_data;
  logic             i_spikes_valid;
  logic             i_spikes_last;
  logic             o_spikes_ready;
  logic [OUT_W-1:0] o_pack_data;
  logic             o_pack_valid;
  logic             o_pack_last;
  logic [CNT_W-1:0] o_pack_count;
  logic             i_pack_ready;

  modport slave (
    input  i_spikes_data, i_spikes_valid, i_spikes_last, i_pack_ready,
    output o_spikes_ready, o_pack_data, o_pack_valid, o_pack_last, o_pack_count
  );

  modport master (
    output i_spikes_data, i_spikes_valid, i_spikes_last, i_pack_ready,
    input  o_spikes_ready, o_pack_data, o_pack_valid, o_pack_last, o_pack_count
  );
endinterface

// File: rtl/spikes_pack_reshaper.sv
// Packs TIME_STEPS x SPIKE_BITS spike slices into words of PACK_NUM slices, with
// valid/ready on both sides, selectable slot order and zero-padded end-of-row flush.
module spikes_pack_reshaper #(
  parameter int TIME_STEPS = 4,
  parameter int SPIKE_BITS = 2,
  parameter int PACK_NUM   = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  s_clk,
  input  logic                  s_rst_n,
  spikes_pack_reshaper_if.slave bus
);
  localparam int IN_W  = TIME_STEPS * SPIKE_BITS;
  localparam int OUT_W = IN_W * PACK_NUM;
  localparam int CNT_W = $clog2(PACK_NUM + 1);

  // Drops one slice into its slot; MSB_FIRST mirrors the slot order within the word.
  function automatic logic [OUT_W-1:0] place_slot(
    input logic [OUT_W-1:0] base,
    input logic [CNT_W-1:0] slot,
    input logic [IN_W-1:0]  beat
  );
    logic [OUT_W-1:0] word;
    word = base;
    for (int k = 0; k < PACK_NUM; k++) begin
      if (slot == CNT_W'(k)) begin
        if (MSB_FIRST != 0) word[OUT_W-(k+1)*IN_W +: IN_W] = beat;
        else                word[k*IN_W +: IN_W]           = beat;
      end
    end
    return word;
  endfunction

  logic [CNT_W-1:0] cnt_p0;
  logic [OUT_W-1:0] acc_p0;
  logic [OUT_W-1:0] acc_nxt;
  logic             beat_acc;
  logic             beat_close;
  logic             spikes_ready;

  logic [OUT_W-1:0] data_p1;
  logic [CNT_W-1:0] count_p1;
  logic             last_p1;
  logic             vld_p1;

  // A held word stalls every beat, so the accumulator never overruns the output register.
  assign spikes_ready = !vld_p1 || bus.i_pack_ready;
  assign beat_acc     = bus.i_spikes_valid && spikes_ready;
  assign beat_close   = (cnt_p0 == CNT_W'(PACK_NUM - 1)) || bus.i_spikes_last;

  always_comb begin
    acc_nxt = place_slot((cnt_p0 == '0) ? {OUT_W{1'b0}} : acc_p0, cnt_p0, bus.i_spikes_data);
  end

  // p0: slice accumulator
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
    end else if (beat_acc) begin
      acc_p0 <= acc_nxt;
      cnt_p0 <= beat_close ? '0 : cnt_p0 + CNT_W'(1);
    end
  end

  // p1: output word register; a same-cycle close replaces a taken word with no bubble
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      data_p1  <= '0;
      count_p1 <= '0;
      last_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (beat_acc && beat_close) begin
      data_p1  <= acc_nxt;
      count_p1 <= cnt_p0 + CNT_W'(1);
      last_p1  <= bus.i_spikes_last;
      vld_p1   <= 1'b1;
    end else if (vld_p1 && bus.i_pack_ready) begin
      count_p1 <= '0;
      last_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end
  end

  assign bus.o_spikes_ready = spikes_ready;
  assign bus.o_pack_data    = data_p1;
  assign bus.o_pack_count   = count_p1;
  assign bus.o_pack_last    = last_p1;
  assign bus.o_pack_valid   = vld_p1;
endmodule

// File: tb/tb_spikes_pack_reshaper.sv
// Scoreboard bench for spikes_pack_reshaper: default, MSB-first and narrow (PACK_NUM=4) instances.
module tb_spikes_pack_reshaper;
  logic s_clk = 1'b0;
  logic s_rst_n;
  always #5 s_clk = ~s_clk;

  spikes_pack_reshaper_if #(.IN_W(8), .OUT_W(64), .CNT_W(4)) bus0 ();
  spikes_pack_reshaper_if #(.IN_W(8), .OUT_W(64), .CNT_W(4)) bus1 ();
  spikes_pack_reshaper_if #(.IN_W(4), .OUT_W(16), .CNT_W(3)) bus2 ();

  spikes_pack_reshaper dut0 (.s_clk(s_clk), .s_rst_n(s_rst_n), .bus(bus0));
  spikes_pack_reshaper #(.MSB_FIRST(1)) dut1 (.s_clk(s_clk), .s_rst_n(s_rst_n), .bus(bus1));
  spikes_pack_reshaper #(.PACK_NUM(4), .SPIKE_BITS(1)) dut2 (.s_clk(s_clk), .s_rst_n(s_rst_n), .bus(bus2));

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  count;
    logic        last;
  } word_t;

  word_t q0[$];
  word_t q1[$];
  word_t q2[$];
  word_t saved[3];
  logic  held[3];
  int    n_chk  = 0;
  int    n_err  = 0;
  int    stalls = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic word_t qpop(input int id);
    case (id)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic expect_word(input int id, input logic [63:0] d, input logic [3:0] c, input logic l);
    word_t w;
    w = '{data: d, count: c, last: l};
    case (id)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  function automatic logic rdy(input int id);
    case (id)
      0:       return bus0.o_spikes_ready;
      1:       return bus1.o_spikes_ready;
      default: return bus2.o_spikes_ready;
    endcase
  endfunction

  task automatic present(input int id, input logic [7:0] d, input logic last);
    case (id)
      0: begin bus0.i_spikes_data = d; bus0.i_spikes_last = last; bus0.i_spikes_valid = 1'b1; end
      1: begin bus1.i_spikes_data = d; bus1.i_spikes_last = last; bus1.i_spikes_valid = 1'b1; end
      default: begin bus2.i_spikes_data = d[3:0]; bus2.i_spikes_last = last; bus2.i_spikes_valid = 1'b1; end
    endcase
  endtask

  task automatic idle(input int id);
    case (id)
      0:       begin bus0.i_spikes_valid = 1'b0; bus0.i_spikes_last = 1'b0; end
      1:       begin bus1.i_spikes_valid = 1'b0; bus1.i_spikes_last = 1'b0; end
      default: begin bus2.i_spikes_valid = 1'b0; bus2.i_spikes_last = 1'b0; end
    endcase
  endtask

  // Presents one beat and holds it until the DUT accepts it (bounded).
  task automatic send(input int id, input logic [7:0] d, input logic last);
    int   guard;
    logic acc;
    present(id, d, last);
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      @(negedge s_clk);
      acc = rdy(id);
      if (!acc) stalls++;
      @(posedge s_clk);
      #1;
      guard++;
    end
    if (!acc) check("send_timeout", 64'(guard), 64'd0);
  endtask

  task automatic mon(input int id, input logic v, input logic pr,
                     input logic [63:0] d, input logic [3:0] c, input logic l);
    word_t e;
    if (v) begin
      if (held[id]) begin
        check($sformatf("hold_data%0d", id),  d,      saved[id].data);
        check($sformatf("hold_count%0d", id), 64'(c), 64'(saved[id].count));
        check($sformatf("hold_last%0d", id),  64'(l), 64'(saved[id].last));
      end
      if (pr) begin
        held[id] = 1'b0;
        if (qsize(id) == 0) begin
          check($sformatf("extra_word%0d", id), 64'(qsize(id)), 64'd1);
        end else begin
          e = qpop(id);
          check($sformatf("word_data%0d", id),  d,      e.data);
          check($sformatf("word_count%0d", id), 64'(c), 64'(e.count));
          check($sformatf("word_last%0d", id),  64'(l), 64'(e.last));
        end
      end else begin
        held[id]  = 1'b1;
        saved[id] = '{data: d, count: c, last: l};
      end
    end else begin
      held[id] = 1'b0;
      if (c != '0) check($sformatf("idle_count%0d", id), 64'(c), 64'd0);
    end
  endtask

  always @(negedge s_clk) begin
    if (s_rst_n === 1'b1) begin
      mon(0, bus0.o_pack_valid, bus0.i_pack_ready, bus0.o_pack_data, bus0.o_pack_count, bus0.o_pack_last);
      mon(1, bus1.o_pack_valid, bus1.i_pack_ready, bus1.o_pack_data, bus1.o_pack_count, bus1.o_pack_last);
      mon(2, bus2.o_pack_valid, bus2.i_pack_ready, 64'(bus2.o_pack_data), 4'(bus2.o_pack_count),
          bus2.o_pack_last);
    end else begin
      for (int i = 0; i < 3; i++) held[i] = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin held[i] = 1'b0; idle(i); end
    bus0.i_spikes_data = '0; bus1.i_spikes_data = '0; bus2.i_spikes_data = '0;
    bus0.i_pack_ready = 1'b1; bus1.i_pack_ready = 1'b1; bus2.i_pack_ready = 1'b1;
    repeat (2) @(posedge s_clk);
    #1;
    check("rst_valid", 64'(bus0.o_pack_valid), 64'd0);
    check("rst_data",  bus0.o_pack_data,       64'd0);
    check("rst_count", 64'(bus0.o_pack_count), 64'd0);
    check("rst_last",  64'(bus0.o_pack_last),  64'd0);
    check("rst_ready", 64'(bus0.o_spikes_ready), 64'd1);
    #2 s_rst_n = 1'b1;
    @(posedge s_clk);
    #1;

    // Full word, then a short row that must not inherit upper slots, then a clean full word
    stalls = 0;
    for (int b = 1; b <= 8; b++) begin
      if (b == 8) expect_word(0, 64'h0807060504030201, 4'd8, 1'b0);
      send(0, 8'(b), 1'b0);
    end
    expect_word(0, 64'h0000000000332211, 4'd3, 1'b1);
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    send(0, 8'h33, 1'b1);
    for (int b = 1; b <= 8; b++) begin
      if (b == 8) expect_word(0, 64'h0807060504030201, 4'd8, 1'b0);
      send(0, 8'(b), 1'b0);
    end
    idle(0);
    check("stream_no_stall", 64'(stalls), 64'd0);
    repeat (3) @(posedge s_clk);
    #1;

    // Backpressure: word 1 held, the next beat stalls until the word is taken
    bus0.i_pack_ready = 1'b0;
    for (int b = 1; b <= 8; b++) begin
      if (b == 8) expect_word(0, 64'h0807060504030201, 4'd8, 1'b0);
      send(0, 8'(b), 1'b0);
    end
    present(0, 8'h09, 1'b0);
    repeat (4) begin
      @(negedge s_clk);
      check("bp_ready_low", 64'(bus0.o_spikes_ready), 64'd0);
      @(posedge s_clk);
      #1;
    end
    bus0.i_pack_ready = 1'b1;
    for (int b = 9; b <= 16; b++) begin
      if (b == 16) expect_word(0, 64'h100F0E0D0C0B0A09, 4'd8, 1'b0);
      send(0, 8'(b), 1'b0);
    end
    idle(0);
    repeat (3) @(posedge s_clk);
    #1;

    // Single-beat rows back to back: close coincides with the take of the previous word
    expect_word(0, 64'h00000000000000AA, 4'd1, 1'b1);
    send(0, 8'hAA, 1'b1);
    expect_word(0, 64'h00000000000000BB, 4'd1, 1'b1);
    send(0, 8'hBB, 1'b1);
    // Last on the final slot gives a full word flagged last
    for (int b = 1; b <= 8; b++) begin
      if (b == 8) expect_word(0, 64'h8877665544332211, 4'd8, 1'b1);
      send(0, 8'(b * 17), b == 8);
    end
    idle(0);
    repeat (3) @(posedge s_clk);
    #1;

    // MSB-first slot order
    for (int b = 1; b <= 8; b++) begin
      if (b == 8) expect_word(1, 64'h0102030405060708, 4'd8, 1'b0);
      send(1, 8'(b), 1'b0);
    end
    idle(1);

    // Narrow variant: 4-bit slices, 4 per word
    for (int b = 1; b <= 4; b++) begin
      if (b == 4) expect_word(2, 64'h4321, 4'd4, 1'b0);
      send(2, 8'(b), 1'b0);
    end
    for (int b = 5; b <= 8; b++) begin
      if (b == 8) expect_word(2, 64'h8765, 4'd4, 1'b1);
      send(2, 8'(b), b == 8);
    end
    idle(2);
    repeat (3) @(posedge s_clk);
    #1;

    // Reset mid-word: partial beats discarded, outputs clear asynchronously
    for (int b = 0; b < 5; b++) send(0, 8'hF0 + 8'(b), 1'b0);
    idle(0);
    @(posedge s_clk);
    #3 s_rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus0.o_pack_valid), 64'd0);
    check("arst_data",  bus0.o_pack_data,       64'd0);
    check("arst_count", 64'(bus0.o_pack_count), 64'd0);
    check("arst_last",  64'(bus0.o_pack_last),  64'd0);
    check("arst_ready", 64'(bus0.o_spikes_ready), 64'd1);
    repeat (2) @(posedge s_clk);
    #3 s_rst_n = 1'b1;
    @(posedge s_clk);
    #1;
    for (int b = 1; b <= 8; b++) begin
      if (b == 8) expect_word(0, 64'h0807060504030201, 4'd8, 1'b0);
      send(0, 8'(b), 1'b0);
    end
    idle(0);
    repeat (5) @(posedge s_clk);
    #1;

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
